qpp_interleave_ctrl: RTL and testbench

Block-level controller for the turbo encoder's QPP interleaver path. Collects one code block of K symbols from an upstream stream, then replays it in QPP-permuted order pi(i) = (F1*i + F2*i*i) mod K. Permuted addresses come from an internal recursive generator, so no multipliers are used. Sits between the systematic bit source and the second constituent encoder.

---
 rtl/qpp_interleave_ctrl.sv | 173 +++++++++++++++++
 tb/tb_qpp_interleave_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/qpp_interleave_ctrl.sv
// qpp_interleave_ctrl: buffers one K-symbol block, replays it in QPP order pi(i) = (F1*i + F2*i*i) mod K.
// Latency: out_data registered 1 cycle after each load; base build block period is 2K+1 cycles.
// Backpressure: out_ready low freezes out_data/out_last; in_ready low while draining (QPP_PINGPONG_EN: two banks overlap fill/drain).
module qpp_interleave_ctrl #(
    parameter int K      = 256,
    parameter int F1     = 15,
    parameter int F2     = 32,
    parameter int DATA_W = 1,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              blk_done
);

    localparam logic [ADDR_W:0]   K_LAST = (ADDR_W+1)'(K - 1);
    localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] KMOD   = ADDR_W'(K);
    localparam logic [ADDR_W-1:0] G_INIT = ADDR_W'((F1 + F2) % K);
    localparam logic [ADDR_W-1:0] G_STEP = ADDR_W'((2 * F2) % K);

    // Write side
    logic [ADDR_W-1:0] r_wcnt;
    logic              w_in_ready;
    logic              w_wr;
    logic              w_fill_last;

    // Read side: r_pi/r_g implement the second-order recurrence of the QPP polynomial
    logic [ADDR_W:0]   r_rcnt;
    logic [ADDR_W-1:0] r_pi;
    logic [ADDR_W-1:0] r_g;
    logic              r_out_valid;
    logic              r_out_last;
    logic [DATA_W-1:0] r_out_data;
    logic              w_can_rd;
    logic              w_ld;
    logic              w_ld_last;
    logic              w_done;
    logic              w_rd_wrap;
    logic [DATA_W-1:0] w_rd_dat;
    logic [ADDR_W:0]   w_pi_sum;
    logic [ADDR_W:0]   w_g_sum;
    logic [ADDR_W-1:0] w_pi_nxt;
    logic [ADDR_W-1:0] w_g_nxt;

`ifdef QPP_PINGPONG_EN
    logic [DATA_W-1:0] r_mem [0:1][0:K-1];
    logic              r_wb;
    logic              r_rb;
    logic [1:0]        r_full;

    // A bank is writable only once its previous drain has fully handshaken out
    assign w_in_ready = !r_full[r_wb];
    assign w_can_rd   = r_full[r_rb];
    // Read pointers rewind on the last load so the next bank can start back-to-back
    assign w_rd_wrap  = w_ld && w_ld_last;
    assign w_rd_dat   = r_mem[r_rb][r_pi];
    assign busy       = r_full[r_rb] || r_out_valid;

    // Store accepted symbols into the current write bank
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wb][r_wcnt] <= in_data;
    end

    // Bank pointers: write bank flips on fill completion, read bank on last load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb <= 1'b0;
            r_rb <= 1'b0;
        end else begin
            if (w_fill_last) r_wb <= ~r_wb;
            if (w_rd_wrap)   r_rb <= ~r_rb;
        end
    end

    // Bank occupancy: set when filled, cleared when its last symbol is taken downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            if (w_fill_last) r_full[r_wb]  <= 1'b1;
            if (w_done)      r_full[~r_rb] <= 1'b0;
        end
    end
`else
    localparam logic [ADDR_W:0] KW      = (ADDR_W+1)'(K);
    localparam logic [0:0]      S_FILL  = 1'b0;
    localparam logic [0:0]      S_DRAIN = 1'b1;

    logic [DATA_W-1:0] r_mem [0:K-1];
    logic [0:0]        r_state;

    assign w_in_ready = (r_state == S_FILL);
    assign w_can_rd   = (r_state == S_DRAIN) && (r_rcnt < KW);
    assign w_rd_wrap  = w_done;
    assign w_rd_dat   = r_mem[r_pi];
    assign busy       = (r_state == S_DRAIN) || r_out_valid;

    // Store accepted symbols in arrival order
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wcnt] <= in_data;
    end

    // FILL/DRAIN sequencing; a block is released only after its last handshake
    always_ff @(posedge clk) begin
        if (rst)                                    r_state <= S_FILL;
        else if (r_state == S_FILL  && w_fill_last) r_state <= S_DRAIN;
        else if (r_state == S_DRAIN && w_done)      r_state <= S_FILL;
    end
`endif

    assign in_ready    = w_in_ready;
    assign w_wr        = in_valid && w_in_ready;
    assign w_fill_last = w_wr && (r_wcnt == W_LAST);
    assign w_ld        = w_can_rd && (!r_out_valid || out_ready);
    assign w_ld_last   = (r_rcnt == K_LAST);
    assign w_done      = r_out_valid && out_ready && r_out_last;

    // Both addends are below K, so one conditional subtract is a full mod K
    assign w_pi_sum = {1'b0, r_pi} + {1'b0, r_g};
    assign w_g_sum  = {1'b0, r_g}  + {1'b0, G_STEP};
    assign w_pi_nxt = (w_pi_sum >= (ADDR_W+1)'(K)) ? (w_pi_sum[ADDR_W-1:0] - KMOD) : w_pi_sum[ADDR_W-1:0];
    assign w_g_nxt  = (w_g_sum  >= (ADDR_W+1)'(K)) ? (w_g_sum[ADDR_W-1:0]  - KMOD) : w_g_sum[ADDR_W-1:0];

    // Write address counter, wraps at the end of each block
    always_ff @(posedge clk) begin
        if (rst)       r_wcnt <= '0;
        else if (w_wr) r_wcnt <= (r_wcnt == W_LAST) ? '0 : r_wcnt + 1'b1;
    end

    // Permuted read address generator and read count
    always_ff @(posedge clk) begin
        if (rst || w_rd_wrap) begin
            r_rcnt <= '0;
            r_pi   <= '0;
            r_g    <= G_INIT;
        end else if (w_ld) begin
            r_rcnt <= r_rcnt + 1'b1;
            r_pi   <= w_pi_nxt;
            r_g    <= w_g_nxt;
        end
    end

    // Output register: load on free slot, hold under stall, clear after handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (w_ld) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_ld_last;
            r_out_data  <= w_rd_dat;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;
    assign blk_done  = w_done;

endmodule

// File: tb/tb_qpp_interleave_ctrl.sv
// tb_qpp_interleave_ctrl: directed bench for the QPP interleaver controller, K=256, DATA_W=8.
// Latency: checks a 2K+1 block period with no stalls.
// Backpressure: exercises random out_ready stalls and in_valid gaps.
module tb_qpp_interleave_ctrl;
    localparam int K = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic       blk_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] got      [0:K-1];
    logic       got_last [0:K-1];
    int n_got, done_cnt, bad_rdy, bad_stable, bad_done, drain_cyc, fill_bad;

    qpp_interleave_ctrl #(.K(256), .F1(15), .F2(32), .DATA_W(8), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .blk_done(blk_done)
    );

    always #5 clk = ~clk;

    function automatic int qpp(input int i);
        return (15 * i + 32 * i * i) % 256;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream one block in; gap=1 drops in_valid every third cycle
    task automatic fill(input bit gap, input bit inv, input bit hold_after);
        int i = 0;
        int cyc = 0;
        bit acc;
        fill_bad = 0;
        while (i < K && cyc < 4 * K) begin
            in_valid = !(gap && (cyc % 3 == 2));
            in_data  = inv ? 8'(255 - i) : 8'(i);
            #1;
            if (in_ready !== 1'b1 || busy !== 1'b0) fill_bad++;
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            cyc++;
        end
        if (i != K) fill_bad++;
        in_valid = hold_after;
        in_data  = 8'hAA;
    endtask

    // Collect up to max_n handshaken outputs with stall_pct percent out_ready=0
    task automatic drain(input int stall_pct, input int max_n);
        bit         stalled_prev = 0;
        logic [7:0] prev_d = '0;
        logic       prev_l = 1'b0;
        n_got = 0; done_cnt = 0; bad_rdy = 0; bad_stable = 0; bad_done = 0; drain_cyc = 0;
        while (n_got < max_n && drain_cyc < 20 * K) begin
            out_ready = ($urandom_range(99) >= stall_pct);
            #1;
            if (stalled_prev && (out_data !== prev_d || out_last !== prev_l)) bad_stable++;
            if (in_ready !== 1'b0 || busy !== 1'b1) bad_rdy++;
            if (blk_done === 1'b1) done_cnt++;
            if (blk_done !== ((out_valid && out_ready && n_got == K - 1) ? 1'b1 : 1'b0)) bad_done++;
            if (out_valid && out_ready) begin
                got[n_got]      = out_data;
                got_last[n_got] = out_last;
                n_got++;
            end
            stalled_prev = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
            @(posedge clk);
            #1;
            drain_cyc++;
        end
        out_ready = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_last"},  out_last,  1'b0);
        check({tag, "_blk_done"},  blk_done,  1'b0);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_in_ready"},  in_ready,  1'b1);
    endtask

    // Compare collected block against the reference permutation
    task automatic check_block(input string tag, input bit inv);
        int bad_val = 0;
        int bad_last = 0;
        int bad_perm = 0;
        int seen [0:K-1];
        for (int i = 0; i < K; i++) seen[i] = 0;
        for (int i = 0; i < K; i++) begin
            if (got[i] !== (inv ? 8'(255 - qpp(i)) : 8'(qpp(i)))) bad_val++;
            if (got_last[i] !== (i == K - 1)) bad_last++;
            if (!$isunknown(got[i])) seen[int'(got[i])]++;
        end
        for (int i = 0; i < K; i++) if (seen[i] != 1) bad_perm++;
        check({tag, "_count"},    n_got,    K);
        check({tag, "_values"},   bad_val,  0);
        check({tag, "_last"},     bad_last, 0);
        check({tag, "_perm"},     bad_perm, 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_pos"}, bad_done, 0);
        check({tag, "_drain_rdy"}, bad_rdy, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_data", out_data, 8'h00);
        check_idle("rst");

        // Block 1: in_data=i, no stalls
        fill(1'b0, 1'b0, 1'b0);
        check("b1_fill_rdy", fill_bad, 0);
        drain(0, K);
        check("b1_out0", got[0], 8'd0);
        check("b1_out1", got[1], 8'd47);
        check("b1_out2", got[2], 8'd158);
        check("b1_out3", got[3], 8'd77);
        check("b1_out255", got[255], 8'd17);
        check("b1_last255", got_last[255], 1'b1);
        check("b1_drain_cycles", drain_cyc, K + 1);
        check_block("b1", 1'b0);
        check_idle("b1_after");

        // Block 2: in_valid gaps, 30% out_ready stalls, in_valid junk during drain
        fill(1'b1, 1'b0, 1'b1);
        check("b2_fill_rdy", fill_bad, 0);
        drain(30, K);
        check("b2_stable", bad_stable, 0);
        check_block("b2", 1'b0);
        check_idle("b2_after");

        // Block 3: abort via reset after 100 outputs
        fill(1'b0, 1'b0, 1'b0);
        drain(0, 100);
        check("b3_partial", n_got, 100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("b3_rst_out_data", out_data, 8'h00);
        check_idle("b3_rst");

        // Block 4: fresh block with in_data=255-i
        fill(1'b0, 1'b1, 1'b0);
        drain(0, K);
        check("b4_out0", got[0], 8'd255);
        check("b4_out1", got[1], 8'd208);
        check("b4_out2", got[2], 8'd97);
        check("b4_out3", got[3], 8'd178);
        check_block("b4", 1'b1);
        check_idle("b4_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
